// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the FIFO-drained UART transmitter: FSM encoding,
// parity mode constants and a frame-length helper.
package uart_defs;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_FETCH  = S_FETCH,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Bit periods in one frame: start + data + optional parity + stop(s).
  function automatic int frame_len(input int dw, input int pe, input int sb);
    return 1 + dw + pe + sb;
  endfunction

endpackage

// File: rtl/uart_tx_drain_baud_cnt.sv
// Bit-period counter: latches the divisor on load, then counts it down and
// pulses bit_tick in the last cycle of every bit period while running.
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= div;
    end else if (run) begin
      cnt <= (cnt == '0) ? div_q : cnt - 1'b1;
    end
  end

  assign bit_tick = run & (cnt == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from the TX FIFO and serialises them as
// start / data (LSB first) / optional parity / stop on a registered txd.
module uart_tx_drain
  import uart_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  par;
  logic                  bit_tick;
  logic                  run;
  logic                  last_stop;

  assign run       = (state != ST_IDLE) && (state != ST_FETCH);
  assign last_stop = (STOP_BITS == 1) | stop_cnt;
  // Gated by rst_n so a held reset never swallows a byte from the FIFO.
  assign fifo_rd_en = rst_n & (state == ST_IDLE) & tx_en & ~fifo_empty;
  assign busy       = (state != ST_IDLE);
  assign tx_done    = (state == ST_STOP) & bit_tick & last_stop;

  uart_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_FETCH),
    .run      (run),
    .div      (baud_div),
    .bit_tick (bit_tick)
  );

  // txd is loaded with the next bit's level on the boundary that enters it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (fifo_rd_en) state <= ST_FETCH;
        ST_FETCH: begin
          shreg    <= fifo_rdata;
          par      <= (^fifo_rdata) ^ (PARITY_ODD != 0);
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          txd      <= 1'b0;
          state    <= ST_START;
        end
        ST_START: if (bit_tick) begin
          txd   <= shreg[0];
          shreg <= shreg >> 1;
          state <= ST_DATA;
        end
        ST_DATA: if (bit_tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              txd   <= par;
              state <= ST_PARITY;
            end else begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end
          end else begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: if (bit_tick) begin
          txd   <= 1'b1;
          state <= ST_STOP;
        end
        ST_STOP: if (bit_tick) begin
          if (last_stop) state <= ST_IDLE;
          else           stop_cnt <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: an 8N1 instance plus 8E2 and 8O1
// instances, with a txd frame decoder checking timing, bits and tx_done.
module tb_uart_tx_drain;
  import uart_defs::*;

  typedef struct {
    logic [7:0] d;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] bd;
  logic        en0;
  logic [7:0]  rdata0 = 8'h00;
  logic [7:0]  rdata_p = 8'h07;
  logic        empty0, empty1, empty2;
  logic        rd0, rd1, rd2;
  logic        txd0, txd1, txd2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [2:0]  txd_v, busy_v, done_v;

  assign txd_v  = {txd2, txd1, txd0};
  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};

  logic [7:0] f0[$];
  exp_t       sb[$];
  int push0 = 0, pop0 = 0, req1 = 0, take1 = 0, req2 = 0, take2 = 0;
  int cyc = 0, last_rd = 0, rd_cnt = 0, viol = 0;
  int n_chk = 0, n_err = 0;

  assign empty0 = (push0 == pop0);
  assign empty1 = (req1 == take1);
  assign empty2 = (req2 == take2);

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .baud_div(bd), .tx_en(en0), .fifo_empty(empty0),
    .fifo_rdata(rdata0), .fifo_rd_en(rd0), .txd(txd0), .busy(busy0), .tx_done(done0));

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(PAR_EVEN), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_div(bd), .tx_en(1'b1), .fifo_empty(empty1),
    .fifo_rdata(rdata_p), .fifo_rd_en(rd1), .txd(txd1), .busy(busy1), .tx_done(done1));

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(PAR_ODD), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_div(bd), .tx_en(1'b1), .fifo_empty(empty2),
    .fifo_rdata(rdata_p), .fifo_rd_en(rd2), .txd(txd2), .busy(busy2), .tx_done(done2));

  // FIFO models: data valid the cycle after the pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin
      last_rd <= cyc;
      rd_cnt  <= rd_cnt + 1;
      if (empty0) viol <= viol + 1;
      if (f0.size() > 0) rdata0 <= f0.pop_front();
      pop0 <= pop0 + 1;
    end
    if (rd1) take1 <= take1 + 1;
    if (rd2) take2 <= take2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v, input int div, input bit score);
    f0.push_back(v);
    push0++;
    if (score) sb.push_back('{v, div});
  endtask

  // Decode one frame on instance i, sampling every negedge.
  task automatic rx_frame(input int i, input int div, input int pe, input int stops,
                          output logic [7:0] d, output logic p, output int st);
    logic s[0:255];
    logic dn[0:255];
    int per, tot, n, ndone, dpos;
    bit stable, stopok;
    per = div + 1;
    tot = frame_len(8, pe, stops) * per;
    n = 0; d = 8'h00; p = 1'b0; st = -1;
    do begin
      @(negedge clk);
      n++;
    end while (txd_v[i] !== 1'b0 && n < 3000);
    if (txd_v[i] !== 1'b0) begin
      chk("start_timeout", 0, 1);
      return;
    end
    st = cyc;
    chk("busy_in_frame", busy_v[i], 1);
    s[0] = txd_v[i]; dn[0] = done_v[i];
    for (int k = 1; k < tot; k++) begin
      @(negedge clk);
      s[k] = txd_v[i]; dn[k] = done_v[i];
    end
    stable = 1'b1;
    for (int k = 0; k < tot; k++) if (s[k] !== s[(k / per) * per]) stable = 1'b0;
    for (int j = 0; j < 8; j++) d[j] = s[(1 + j) * per];
    if (pe != 0) p = s[9 * per];
    stopok = 1'b1;
    for (int k = (9 + pe) * per; k < tot; k++) if (s[k] !== 1'b1) stopok = 1'b0;
    ndone = 0; dpos = -1;
    for (int k = 0; k < tot; k++) if (dn[k] === 1'b1) begin ndone++; dpos = k; end
    chk("start_bit", s[0], 0);
    chk("bit_hold", stable, 1);
    chk("stop_bits", stopok, 1);
    chk("done_cnt", ndone, 1);
    chk("done_pos", dpos, tot - 1);
  endtask

  initial begin
    exp_t       e;
    logic [7:0] d, d1, d2, pv;
    logic       p, p1, p2;
    int         st, st1, st2, r0, prev_end, n;

    rst_n = 1'b0; en0 = 1'b0; bd = 16'd3;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_rd", rd0, 0);
    chk("rst_done", done0, 0);
    chk("rst_txd_par", txd1, 1);
    rst_n = 1'b1; en0 = 1'b1;

    // 8N1 single byte, 4-cycle bits
    r0 = rd_cnt;
    push(8'hA5, 3, 1);
    e = sb.pop_front();
    rx_frame(0, e.div, 0, 1, d, p, st);
    chk("t1_data", d, e.d);
    chk("t1_rd_pulses", rd_cnt - r0, 1);
    chk("t1_latency", st - last_rd, 2);

    // back-to-back at one cycle per bit
    bd = 16'd0; r0 = rd_cnt; prev_end = 0;
    push(8'h01, 0, 1); push(8'h02, 0, 1); push(8'h03, 0, 1);
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      rx_frame(0, e.div, 0, 1, d, p, st);
      chk("t2_data", d, e.d);
      if (k > 0) chk("t2_gap", st - prev_end, 2);
      prev_end = st + frame_len(8, 0, 1);
    end
    chk("t2_rd_pulses", rd_cnt - r0, 3);

    // parity instances
    bd = 16'd1; pv = 8'h07;
    req1++; req2++;
    fork
      rx_frame(1, 1, 1, 2, d1, p1, st1);
      rx_frame(2, 1, 1, 1, d2, p2, st2);
    join
    chk("t3_even_data", d1, pv);
    chk("t3_even_par", p1, ^pv);
    chk("t3_odd_data", d2, pv);
    chk("t3_odd_par", p2, ~^pv);

    // tx_en gating
    en0 = 1'b0; r0 = rd_cnt;
    push(8'h3C, 1, 1);
    repeat (20) @(negedge clk);
    chk("t4_no_pop", rd_cnt - r0, 0);
    chk("t4_idle_txd", txd0, 1);
    chk("t4_idle_busy", busy0, 0);
    en0 = 1'b1;
    fork
      begin
        e = sb.pop_front();
        rx_frame(0, e.div, 0, 1, d, p, st);
        chk("t4_data", d, e.d);
      end
      begin
        n = 0;
        while (!busy0 && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        en0 = 1'b0;
        push(8'h99, 1, 0);
      end
    join
    repeat (20) @(negedge clk);
    chk("t4_one_pop", rd_cnt - r0, 1);
    chk("t4_txd_after", txd0, 1);
    chk("t4_busy_after", busy0, 0);

    // reset during data bit 3; the 0x99 in flight is discarded
    push(8'h5A, 1, 1);
    en0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (txd0 !== 1'b0 && n < 100);
    chk("t5_start_seen", txd0, 0);
    repeat (8) @(negedge clk);
    chk("t5_bit3", txd0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_txd", txd0, 1);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_rd", rd0, 0);
    @(negedge clk);
    rst_n = 1'b1; r0 = rd_cnt;
    e = sb.pop_front();
    rx_frame(0, e.div, 0, 1, d, p, st);
    chk("t5_data", d, e.d);
    chk("t5_rd_pulses", rd_cnt - r0, 1);

    // divisor change mid-frame applies to the next frame
    bd = 16'd3;
    push(8'hC3, 3, 1);
    push(8'h6E, 7, 1);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          e = sb.pop_front();
          rx_frame(0, e.div, 0, 1, d, p, st);
          chk("t6_data", d, e.d);
        end
      end
      begin
        n = 0;
        while (!busy0 && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        bd = 16'd7;
      end
    join

    chk("rd_when_empty", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

endmodule
